// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: packs little-endian words into imem, then releases the core.
// Optional LOADER_CHECKSUM_EN adds a trailing 32-bit sum check (CHK) before DONE.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    HDR, DATA, CHK, DONE, ERR
  } state_t;

  localparam logic [CNT_WIDTH:0] CAP =
    (CNT_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH+1)'(1);

  state_t                state;
  logic [1:0]            bidx;
  logic [23:0]           acc;
  logic [ADDR_WIDTH:0]   nwords;
  logic                  take;
  logic                  last;
  logic [CNT_WIDTH-1:0]  word;

  assign take = in_valid && in_ready;
  assign last = (bidx == 2'd3);
  assign word = {in_byte, acc};

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;

  // Running sum of data words for the trailing checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (state == DATA && take && last) begin
      sum <= sum + word;
    end
  end
`endif

  // Loader FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HDR;
      bidx         <= '0;
      acc          <= '0;
      nwords       <= '0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (take) begin
        bidx <= bidx + 2'd1;
        acc  <= {in_byte, acc[23:8]};
      end
      unique case (state)
        HDR: begin
          in_ready <= 1'b1;
          if (take && last) begin
            if ({1'b0, word} > CAP) begin
              state    <= ERR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end else if (word == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= CHK;
`else
              state    <= DONE;
              in_ready <= 1'b0;
`endif
            end else begin
              state  <= DATA;
              nwords <= word[ADDR_WIDTH:0];
            end
          end
        end
        DATA: begin
          if (take && last) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
            imem_wdata   <= word;
            words_loaded <= words_loaded + ONE;
            if (words_loaded + ONE == nwords) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= CHK;
`else
              state    <= DONE;
              in_ready <= 1'b0;
`endif
            end
          end
        end
        CHK: begin
`ifdef LOADER_CHECKSUM_EN
          if (take && last) begin
            in_ready <= 1'b0;
            if (word == sum) begin
              state <= DONE;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
`else
          state    <= ERR;
          in_ready <= 1'b0;
          load_err <= 1'b1;
`endif
        end
        DONE: begin
          in_ready   <= 1'b0;
          core_rst_n <= 1'b1;
          load_done  <= 1'b1;
        end
        ERR: begin
          in_ready   <= 1'b0;
          core_rst_n <= 1'b0;
          load_err   <= 1'b1;
        end
        default: begin
          state    <= ERR;
          in_ready <= 1'b0;
          load_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: stream-level reference model plus directed scenarios.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum scenario.
module tb_imem_boot_loader;

  localparam int AW = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_byte = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  imem_boot_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- stream-level reference model ----------------
  logic [7:0]      q[$];
  longint unsigned nhdr;
  logic [31:0]     msum;
  bit              fin;
  bit              m_ready, m_we, m_done, m_rstn, m_err;
  int              m_addr, m_wl;
  logic [31:0]     m_wdata;

  always @(posedge clk) begin
    bit was_fin;
    int n;
    logic [31:0] w;
    if (rst) begin
      q.delete();
      nhdr = 0; msum = 0; fin = 0;
      m_ready = 0; m_we = 0; m_done = 0; m_rstn = 0; m_err = 0;
      m_addr = 0; m_wl = 0; m_wdata = 0;
    end else begin
      was_fin = fin;
      m_we = 0;
      if (m_ready && in_valid) begin
        q.push_back(in_byte);
        n = q.size();
        if (n % 4 == 0) begin
          w = {q[n-1], q[n-2], q[n-3], q[n-4]};
          if (n == 4) begin
            nhdr = longint'(w);
            if (nhdr > (longint'(1) << AW)) m_err = 1;
            else if (nhdr == 0) fin = !CK;
          end else if (longint'(n/4 - 2) < nhdr) begin
            m_we = 1; m_addr = n/4 - 2; m_wdata = w;
            m_wl++; msum = msum + w;
            if (longint'(n/4 - 1) == nhdr) fin = !CK;
          end else if (CK && longint'(n/4 - 2) == nhdr) begin
            if (w == msum) fin = 1; else m_err = 1;
          end
        end
      end
      if (was_fin) begin m_done = 1; m_rstn = 1; end
      m_ready = !fin && !m_err;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    n_checks++;
    if (in_ready !== m_ready || imem_we !== m_we || load_done !== m_done ||
        core_rst_n !== m_rstn || load_err !== m_err ||
        words_loaded !== (AW+1)'(m_wl) ||
        (m_we && (imem_addr !== AW'(m_addr) || imem_wdata !== m_wdata))) begin
      n_fail++;
      $display("FAIL model cyc=%0d got rdy=%b we=%b a=%0d d=%h rn=%b dn=%b er=%b wl=%0d exp rdy=%b we=%b a=%0d d=%h rn=%b dn=%b er=%b wl=%0d",
        cyc, in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, load_done,
        load_err, words_loaded, m_ready, m_we, m_addr, m_wdata, m_rstn,
        m_done, m_err, m_wl);
    end
  end

  // ---------------- write log from the DUT ----------------
  int          wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          wlog_cyc[$];

  always @(posedge clk) begin
    #2;
    if (imem_we) begin
      wlog_addr.push_back(int'(imem_addr));
      wlog_data.push_back(imem_wdata);
      wlog_cyc.push_back(cyc);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
    rst = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    @(negedge clk);
    in_valid = 1; in_byte = b;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout byte=%h in_ready=%b expected 1", b, in_ready);
    end
    @(posedge clk);
  endtask

  task automatic raw(input logic [7:0] b, input logic v);
    @(negedge clk);
    in_valid = v; in_byte = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0; in_byte = 8'hEE;
    end
  endtask

  logic [7:0] img[12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                          8'h13, 8'h05, 8'hA0, 8'h00,
                          8'h03, 8'hA5, 8'h05, 8'h00};

  task automatic send_img();
    for (int i = 0; i < 12; i++) send(img[i]);
  endtask

  task automatic check_img(input string tag);
    chk({tag, "_nwr"}, wlog_data.size(), 2);
    if (wlog_data.size() == 2) begin
      chk({tag, "_a0"}, wlog_addr[0], 0);
      chk({tag, "_d0"}, wlog_data[0], 32'h00A00513);
      chk({tag, "_a1"}, wlog_addr[1], 1);
      chk({tag, "_d1"}, wlog_data[1], 32'h0005A503);
      chk({tag, "_gap"}, wlog_cyc[1] - wlog_cyc[0], 4);
    end
    chk({tag, "_wl"}, words_loaded, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_rstn", core_rst_n, 0);
    chk("rst_wl", words_loaded, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // 1: two-word image at full rate
    send_img();
    idle(3);
    check_img("s1");
`ifndef LOADER_CHECKSUM_EN
    chk("s1_done", load_done, 1);
    chk("s1_rstn", core_rst_n, 1);
    chk("s1_ready", in_ready, 0);
`endif

    // 2: empty image
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h00);
    idle(3);
    chk("s2_nwr", wlog_data.size(), 0);
`ifndef LOADER_CHECKSUM_EN
    chk("s2_done", load_done, 1);
    chk("s2_rstn", core_rst_n, 1);
`endif

    // 3: oversize header
    do_reset();
    send(8'h01); send(8'h01); send(8'h00); send(8'h00);
    idle(1);
    chk("s3_err", load_err, 1);
    chk("s3_ready", in_ready, 0);
    chk("s3_rstn", core_rst_n, 0);
    for (int i = 0; i < 8; i++) raw(8'(i), 1'b1);
    idle(2);
    chk("s3_nwr", wlog_data.size(), 0);
    chk("s3_err_held", load_err, 1);

    // 4: one word with gaps in in_valid
    do_reset();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    raw(8'h11, 1); raw(8'h99, 0); raw(8'h98, 0); raw(8'h22, 1);
    raw(8'h97, 0); raw(8'h33, 1); raw(8'h44, 1);
    idle(3);
    chk("s4_nwr", wlog_data.size(), 1);
    if (wlog_data.size() == 1) chk("s4_word", wlog_data[0], 32'h44332211);
    chk("s4_wl", words_loaded, 1);

    // 5: reset mid-load then full reload
    do_reset();
    for (int i = 0; i < 6; i++) send(img[i]);
    @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    chk("s5_ready", in_ready, 0);
    chk("s5_wl", words_loaded, 0);
    chk("s5_rstn", core_rst_n, 0);
    chk("s5_we", imem_we, 0);
    wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
    rst = 0;
    send_img();
    idle(3);
    check_img("s5");
`ifndef LOADER_CHECKSUM_EN
    chk("s5_done", load_done, 1);
`endif

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum good and bad
    do_reset();
    send_img();
    send(8'h16); send(8'hAA); send(8'hA5); send(8'h00);
    idle(3);
    chk("s6_done", load_done, 1);
    chk("s6_err", load_err, 0);
    do_reset();
    send_img();
    send(8'h17); send(8'hAA); send(8'hA5); send(8'h00);
    idle(3);
    chk("s6b_err", load_err, 1);
    chk("s6b_rstn", core_rst_n, 0);
    chk("s6b_done", load_done, 0);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Upstream stage of the single-cycle RISC-V core. Receives a program image as a byte stream over a valid/ready interface. Assembles little-endian 32-bit words and writes them into instruction memory. Holds the core in reset until the load completes, then releases it.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words
CNT_WIDTH, 32, width of header word count; fixed at 32, exposed for lint only

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
in_byte  input  8  stream data byte
in_valid  input  1  in_byte valid
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address for the write
imem_wdata  output  32  word to write
core_rst_n  output  1  reset to the core; 0 = hold in reset, 1 = run
load_done  output  1  image loaded, core released
load_err  output  1  image rejected; sticky until rst
words_loaded  output  ADDR_WIDTH+1  count of words written so far

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, load_done=0, load_err=0, words_loaded=0, state=HDR, byte index=0.
- in_ready is 1 in HDR, DATA and CHK. It is 0 during the reset cycle and in DONE and ERR. It goes to 1 on the first edge after rst deasserts.
- A byte is accepted on a rising edge where in_valid && in_ready. in_byte is ignored otherwise.
- Byte packing: a 2-bit byte index wraps 3->0. The first accepted byte maps to [7:0] and the fourth to [31:24] (little-endian).
- HDR: four bytes form N, the word count.
  - N==0 -> DONE.
  - N>2^ADDR_WIDTH -> ERR.
  - Otherwise -> DATA.
- DATA: on the edge accepting the 4th byte of word k, the following outputs apply for exactly one cycle after that edge:
  - imem_we=1, imem_addr=k, imem_wdata=word.
  - words_loaded increments on the same edge.
- DATA back-to-back: in_ready stays 1, so a full-rate stream writes one word every 4 cycles.
- DATA exit: on the 4th byte of word N-1 -> DONE (or CHK when LOADER_CHECKSUM_EN is defined). That word's write strobe still fires in the cycle after this edge.
- DONE: on the edge after entering DONE, core_rst_n=1 and load_done=1. Both stay at 1 until rst.
- ERR: load_err=1 and core_rst_n=0. The loader ignores input. Only rst exits ERR.
- imem_addr wraps never: N is range-checked in HDR.
- rst mid-load: everything returns to reset values and a new header is expected. Memory contents already written are not cleared. core_rst_n drops to 0 on the same edge.
- in_valid may drop between bytes of a word. Partial-word state is held with no timeout.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - After word N-1 the loader enters CHK and accepts 4 more bytes, C, little-endian.
  - S is the running sum of all data words mod 2^32; the header is excluded.
  - C==S -> DONE. C!=S -> ERR.
  - For N==0 the loader still enters CHK with S=0.
- Not defined: there is no CHK state. DATA goes directly to DONE, and N==0 goes HDR->DONE.

Test Plan:
1. Reset, then stream bytes 02 00 00 00 | 13 05 A0 00 | 03 A5 05 00 at full rate -> imem_we pulses with (addr 0, 0x00A00513), then 4 cycles later (addr 1, 0x0005A503). The next edge gives core_rst_n=1 and load_done=1, with words_loaded=2.
2. Header 00 00 00 00 (macro off) -> DONE one edge after the 4th byte with no imem_we pulse. The following edge gives core_rst_n=1.
3. ADDR_WIDTH=8, header 01 01 00 00 (N=257) -> load_err=1, in_ready=0, core_rst_n held at 0. Further bytes are ignored until rst.
4. Bytes of one word presented with in_valid toggling 1,0,0,1,0,1,1 -> a single write of the correctly ordered word, and no spurious imem_we.
5. Assert rst after 6 bytes of scenario 1 -> all outputs return to reset values. Re-streaming the full image then reproduces scenario 1 exactly.
6. With LOADER_CHECKSUM_EN defined, scenario 1 followed by checksum bytes 16 AA A5 00 (0x00A5AA16) -> load_done=1. Checksum bytes 17 AA A5 00 -> load_err=1 and core_rst_n stays at 0.
